// File: rtl/icache_l1.sv
// Direct-mapped, read-only L1 instruction cache. Hits answer the same cycle and
// data follows on the next one. Misses refill a whole line and deliver the requested beat.
module icache_l1 #(
   parameter int SETS       = 16,
   parameter int LINE_BEATS = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ioMem_ren,
   input  logic [31:0] ioMem_addr,
   output logic [63:0] ioMem_rData,
   output logic        ioMem_hit,
   output logic        ioMem_rvalid,
   input  logic        ioMem_wen,
   input  logic        io_fencei,
   output logic        io_busy,
   output logic        ioBus_arvalid,
   input  logic        ioBus_arready,
   output logic [31:0] ioBus_araddr,
   input  logic        ioBus_rvalid,
   input  logic [63:0] ioBus_rdata,
   input  logic        ioBus_rlast
);
   localparam int BW = $clog2(LINE_BEATS);
   localparam int IW = $clog2(SETS);
   localparam int OW = 3 + BW;
   localparam int TW = 32 - OW - IW;

   typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

   state_t            state_q, state_d;
   logic [31:0]       addr_q, addr_d;
   logic [BW-1:0]     cnt_q, cnt_d;
   logic              pend_q, pend_d;
   logic [SETS-1:0]   valid_q, valid_d;
   logic [63:0]       rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;
   logic              arvalid_q, arvalid_d;
   logic [31:0]       araddr_q, araddr_d;
   logic              dwe, twe, hit;

   logic [TW-1:0]     tag_mem  [SETS];
   logic [63:0]       data_mem [SETS][LINE_BEATS];

   logic [IW-1:0] req_idx, fill_idx;
   logic [BW-1:0] req_beat, fill_beat;
   logic [TW-1:0] req_tag, fill_tag;
   logic          unused_ok;

   assign req_idx   = ioMem_addr[OW +: IW];
   assign req_beat  = ioMem_addr[3 +: BW];
   assign req_tag   = ioMem_addr[OW+IW +: TW];
   assign fill_idx  = addr_q[OW +: IW];
   assign fill_beat = addr_q[3 +: BW];
   assign fill_tag  = addr_q[OW+IW +: TW];
   assign unused_ok = ^{ioMem_wen, ioMem_addr[2:0]};

   assign hit = ioMem_ren && (state_q == IDLE) && !io_fencei &&
                valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      valid_d   = valid_q;
      rdata_d   = rdata_q;
      rvalid_d  = 1'b0;
      arvalid_d = arvalid_q;
      araddr_d  = araddr_q;
      dwe       = 1'b0;
      twe       = 1'b0;
      case (state_q)
         IDLE: begin
            if (io_fencei) valid_d = '0;
            if (hit) begin
               rdata_d = data_mem[req_idx][req_beat];
            end else if (ioMem_ren) begin
               addr_d    = ioMem_addr;
               araddr_d  = {ioMem_addr[31:OW], {OW{1'b0}}};
               arvalid_d = 1'b1;
               state_d   = REQ;
            end
         end
         REQ: begin
            if (io_fencei) pend_d = 1'b1;
            if (ioBus_arready) begin
               arvalid_d = 1'b0;
               cnt_d     = '0;
               state_d   = FILL;
            end
         end
         FILL: begin
            // The rvalid pulse cycle is still FILL, so a ren landing on it is dropped.
            if (rvalid_q) begin
               state_d = IDLE;
               if (io_fencei) valid_d = '0;
            end else begin
               if (io_fencei) pend_d = 1'b1;
               if (ioBus_rvalid) begin
                  dwe   = 1'b1;
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == fill_beat) rdata_d = ioBus_rdata;
                  if (ioBus_rlast || cnt_q == BW'(LINE_BEATS-1)) begin
                     twe               = 1'b1;
                     valid_d[fill_idx] = 1'b1;
                     rvalid_d          = 1'b1;
                     pend_d            = 1'b0;
                     if (pend_q || io_fencei) valid_d = '0;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         cnt_q     <= '0;
         pend_q    <= 1'b0;
         valid_q   <= '0;
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
         araddr_q  <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         valid_q   <= valid_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
         arvalid_q <= arvalid_d;
         araddr_q  <= araddr_d;
      end
   end

   always_ff @(posedge clock) begin
      if (dwe) data_mem[fill_idx][cnt_q] <= ioBus_rdata;
      if (twe) tag_mem[fill_idx] <= fill_tag;
   end

   assign ioMem_rData   = rdata_q;
   assign ioMem_hit     = hit;
   assign ioMem_rvalid  = rvalid_q;
   assign io_busy       = (state_q != IDLE) || pend_q;
   assign ioBus_arvalid = arvalid_q;
   assign ioBus_araddr  = araddr_q;
endmodule

// File: tb/tb_icache_l1.sv
// Directed bench for icache_l1: the bench plays the bus slave and checks hits, refills,
// conflicts, fence.i and asynchronous reset against hand-computed values.
module tb_icache_l1;
   logic        clock = 1'b0;
   logic        reset;
   logic        ioMem_ren = 1'b0;
   logic [31:0] ioMem_addr = '0;
   logic [63:0] ioMem_rData;
   logic        ioMem_hit;
   logic        ioMem_rvalid;
   logic        ioMem_wen = 1'b0;
   logic        io_fencei = 1'b0;
   logic        io_busy;
   logic        ioBus_arvalid;
   logic        ioBus_arready = 1'b0;
   logic [31:0] ioBus_araddr;
   logic        ioBus_rvalid = 1'b0;
   logic [63:0] ioBus_rdata = '0;
   logic        ioBus_rlast = 1'b0;

   int pass_cnt = 0;
   int total_cnt = 0;

   localparam logic [63:0] D1 = 64'h1111111111111111;
   localparam logic [63:0] D2 = 64'h2222222222222222;
   localparam logic [63:0] D3 = 64'h3333333333333333;
   localparam logic [63:0] D4 = 64'h4444444444444444;
   localparam logic [63:0] D5 = 64'h5555555555555555;
   localparam logic [63:0] D6 = 64'h6666666666666666;
   localparam logic [63:0] D7 = 64'h7777777777777777;
   localparam logic [63:0] D8 = 64'h8888888888888888;

   icache_l1 #(.SETS(16), .LINE_BEATS(2)) dut (
      .clock(clock), .reset(reset),
      .ioMem_ren(ioMem_ren), .ioMem_addr(ioMem_addr), .ioMem_rData(ioMem_rData),
      .ioMem_hit(ioMem_hit), .ioMem_rvalid(ioMem_rvalid), .ioMem_wen(ioMem_wen),
      .io_fencei(io_fencei), .io_busy(io_busy),
      .ioBus_arvalid(ioBus_arvalid), .ioBus_arready(ioBus_arready), .ioBus_araddr(ioBus_araddr),
      .ioBus_rvalid(ioBus_rvalid), .ioBus_rdata(ioBus_rdata), .ioBus_rlast(ioBus_rlast)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Bus-slave refill: fmode 0 = no fence, 1 = fence with the request, 2 = fence during FILL.
   task automatic refill(input logic [31:0] a, input int w, input logic [63:0] b0, input logic [63:0] b1,
                         input int fmode, output logic hit0, output logic arv_ok,
                         output logic [31:0] ara, output logic rv_early, output logic rv,
                         output logic [63:0] rd, output logic busy_end);
      ioMem_ren = 1'b1; ioMem_addr = a;
      if (fmode == 1) io_fencei = 1'b1;
      #3 hit0 = ioMem_hit;
      tick();
      ioMem_ren = 1'b0; io_fencei = 1'b0;
      arv_ok = 1'b1;
      for (int i = 0; i < w; i++) begin
         #3 if (ioBus_arvalid !== 1'b1) arv_ok = 1'b0;
         tick();
      end
      ioBus_arready = 1'b1;
      #3 if (ioBus_arvalid !== 1'b1) arv_ok = 1'b0;
      ara = ioBus_araddr;
      tick();
      ioBus_arready = 1'b0;
      #1 if (ioBus_arvalid !== 1'b0) arv_ok = 1'b0;
      ioBus_rvalid = 1'b1; ioBus_rdata = b0; ioBus_rlast = 1'b0;
      if (fmode == 2) io_fencei = 1'b1;
      tick();
      io_fencei = 1'b0;
      ioBus_rdata = b1; ioBus_rlast = 1'b1;
      #3 rv_early = ioMem_rvalid;
      tick();
      ioBus_rvalid = 1'b0; ioBus_rlast = 1'b0;
      #3 rv = ioMem_rvalid; rd = ioMem_rData; busy_end = io_busy;
      tick();
   endtask

   task automatic test_reset();
      total_cnt++;
      if ({ioMem_rData, ioMem_hit, ioMem_rvalid, ioBus_arvalid, ioBus_araddr, io_busy} !== '0)
         $display("FAIL reset_outputs rData=%h hit=%b rvalid=%b arvalid=%b araddr=%h busy=%b want all 0",
                  ioMem_rData, ioMem_hit, ioMem_rvalid, ioBus_arvalid, ioBus_araddr, io_busy);
      else pass_cnt++;
   endtask

   task automatic test_cold_miss();
      logic h, ok, re, rv, b; logic [31:0] ara; logic [63:0] rd;
      refill(32'h80000000, 2, D1, D2, 0, h, ok, ara, re, rv, rd, b);
      total_cnt++; if (h !== 1'b0) $display("FAIL cold_hit got=%b want=0", h); else pass_cnt++;
      total_cnt++; if (ok !== 1'b1) $display("FAIL cold_arvalid_hold got=%b want=1", ok); else pass_cnt++;
      total_cnt++; if (ara !== 32'h80000000) $display("FAIL cold_araddr got=%h want=80000000", ara); else pass_cnt++;
      total_cnt++; if (re !== 1'b0) $display("FAIL cold_rvalid_early got=%b want=0", re); else pass_cnt++;
      total_cnt++; if (rv !== 1'b1) $display("FAIL cold_rvalid got=%b want=1", rv); else pass_cnt++;
      total_cnt++; if (rd !== D1) $display("FAIL cold_rdata got=%h want=%h", rd, D1); else pass_cnt++;
      total_cnt++; if (b !== 1'b1) $display("FAIL cold_busy_pulse got=%b want=1", b); else pass_cnt++;
      #3;
      total_cnt++; if (ioMem_rvalid !== 1'b0) $display("FAIL cold_rvalid_one_cycle got=%b want=0", ioMem_rvalid); else pass_cnt++;
      total_cnt++; if (io_busy !== 1'b0) $display("FAIL cold_busy_after got=%b want=0", io_busy); else pass_cnt++;
      tick();
   endtask

   task automatic test_hit();
      ioMem_ren = 1'b1; ioMem_addr = 32'h80000008;
      #3;
      total_cnt++; if (ioMem_hit !== 1'b1) $display("FAIL hit_flag got=%b want=1", ioMem_hit); else pass_cnt++;
      tick();
      ioMem_ren = 1'b0;
      #3;
      total_cnt++; if (ioMem_rData !== D2) $display("FAIL hit_rdata got=%h want=%h", ioMem_rData, D2); else pass_cnt++;
      total_cnt++; if (ioMem_rvalid !== 1'b0) $display("FAIL hit_rvalid got=%b want=0", ioMem_rvalid); else pass_cnt++;
      tick();
      ioMem_ren = 1'b1; ioMem_addr = 32'h80000000;
      tick();
      ioMem_ren = 1'b0;
      #3;
      total_cnt++; if (ioMem_rData !== D1) $display("FAIL hit_beat0 got=%h want=%h", ioMem_rData, D1); else pass_cnt++;
      tick();
   endtask

   task automatic test_critical_beat();
      logic h, ok, re, rv, b; logic [31:0] ara; logic [63:0] rd;
      refill(32'h80000018, 0, D3, D4, 0, h, ok, ara, re, rv, rd, b);
      total_cnt++; if (ara !== 32'h80000010) $display("FAIL crit_araddr got=%h want=80000010", ara); else pass_cnt++;
      total_cnt++; if (rv !== 1'b1 || rd !== D4) $display("FAIL crit_rdata got=%b/%h want=1/%h", rv, rd, D4); else pass_cnt++;
      ioMem_ren = 1'b1; ioMem_addr = 32'h80000010;
      #3;
      total_cnt++; if (ioMem_hit !== 1'b1) $display("FAIL crit_rehit got=%b want=1", ioMem_hit); else pass_cnt++;
      tick();
      ioMem_ren = 1'b0;
      #3;
      total_cnt++; if (ioMem_rData !== D3) $display("FAIL crit_rehit_data got=%h want=%h", ioMem_rData, D3); else pass_cnt++;
      tick();
   endtask

   task automatic test_conflict();
      logic h, ok, re, rv, b; logic [31:0] ara; logic [63:0] rd;
      refill(32'h80000100, 1, D5, D6, 0, h, ok, ara, re, rv, rd, b);
      total_cnt++; if (h !== 1'b0) $display("FAIL conflict_hit got=%b want=0", h); else pass_cnt++;
      total_cnt++; if (ara !== 32'h80000100 || rd !== D5) $display("FAIL conflict_fill got=%h/%h want=80000100/%h", ara, rd, D5); else pass_cnt++;
      refill(32'h80000000, 0, D1, D2, 0, h, ok, ara, re, rv, rd, b);
      total_cnt++; if (h !== 1'b0) $display("FAIL conflict_evicted_hit got=%b want=0", h); else pass_cnt++;
      total_cnt++; if (rv !== 1'b1 || rd !== D1) $display("FAIL conflict_refill got=%b/%h want=1/%h", rv, rd, D1); else pass_cnt++;
   endtask

   task automatic test_fencei();
      logic h, ok, re, rv, b; logic [31:0] ara; logic [63:0] rd;
      refill(32'h80000020, 0, D7, D8, 2, h, ok, ara, re, rv, rd, b);
      total_cnt++; if (rv !== 1'b1 || rd !== D7) $display("FAIL fence_fill got=%b/%h want=1/%h", rv, rd, D7); else pass_cnt++;
      total_cnt++; if (b !== 1'b1) $display("FAIL fence_busy got=%b want=1", b); else pass_cnt++;
      #3;
      total_cnt++; if (io_busy !== 1'b0) $display("FAIL fence_busy_after got=%b want=0", io_busy); else pass_cnt++;
      tick();
      refill(32'h80000020, 0, D7, D8, 0, h, ok, ara, re, rv, rd, b);
      total_cnt++; if (h !== 1'b0) $display("FAIL fence_new_line_hit got=%b want=0", h); else pass_cnt++;
      refill(32'h80000000, 0, D1, D2, 0, h, ok, ara, re, rv, rd, b);
      total_cnt++; if (h !== 1'b0) $display("FAIL fence_old_line_hit got=%b want=0", h); else pass_cnt++;
      // Fence in IDLE together with ren on a resident line: forced miss, line reinstalled.
      refill(32'h80000000, 0, D1, D2, 1, h, ok, ara, re, rv, rd, b);
      total_cnt++; if (h !== 1'b0 || rd !== D1) $display("FAIL fence_idle_miss got=%b/%h want=0/%h", h, rd, D1); else pass_cnt++;
      ioMem_ren = 1'b1; ioMem_addr = 32'h80000008;
      #3;
      total_cnt++; if (ioMem_hit !== 1'b1) $display("FAIL fence_idle_rehit got=%b want=1", ioMem_hit); else pass_cnt++;
      tick();
      ioMem_ren = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_fill();
      logic h, ok, re, rv, b; logic [31:0] ara; logic [63:0] rd;
      ioMem_ren = 1'b1; ioMem_addr = 32'h80000030;
      tick();
      ioMem_ren = 1'b0; ioBus_arready = 1'b1;
      tick();
      ioBus_arready = 1'b0; ioBus_rvalid = 1'b1; ioBus_rdata = 64'hAAAAAAAAAAAAAAAA;
      tick();
      ioBus_rvalid = 1'b0;
      #2 reset = 1'b1;
      #1;
      total_cnt++;
      if ({ioMem_rData, ioMem_hit, ioMem_rvalid, ioBus_arvalid, ioBus_araddr, io_busy} !== '0)
         $display("FAIL midfill_reset rData=%h hit=%b rvalid=%b arvalid=%b araddr=%h busy=%b want all 0",
                  ioMem_rData, ioMem_hit, ioMem_rvalid, ioBus_arvalid, ioBus_araddr, io_busy);
      else pass_cnt++;
      @(negedge clock) reset = 1'b0;
      tick();
      refill(32'h80000000, 0, D1, D2, 0, h, ok, ara, re, rv, rd, b);
      total_cnt++; if (h !== 1'b0) $display("FAIL midfill_after_hit got=%b want=0", h); else pass_cnt++;
      total_cnt++; if (rv !== 1'b1 || rd !== D1) $display("FAIL midfill_refill got=%b/%h want=1/%h", rv, rd, D1); else pass_cnt++;
   endtask

   initial begin
      reset = 1'b1;
      #12 reset = 1'b0;
      tick();
      test_reset();
      test_cold_miss();
      test_hit();
      test_critical_beat();
      test_conflict();
      test_fencei();
      test_reset_mid_fill();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
